// File: rtl/hub75_sink.sv
// HUB75 panel-bus sink: rebuilds each latched row and reports its lit time; HUB75_SINK_ERR_EN adds the shift-count error flag.
// Reports arrive one cycle after the oe falling edge; the bus is always accepted, there is no backpressure.
module hub75_sink #(
    parameter int rows       = 8,
    parameter int columns    = 32,
    parameter int cyclewidth = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      oclk,
    input  logic                      lat,
    input  logic                      oe,
    input  logic [$clog2(rows)-1:0]   row,
    input  logic [2:0]                rgb,
    output logic                      row_valid,
    output logic [$clog2(rows)-1:0]   row_index,
    output logic [cyclewidth-1:0]     row_on_cycles,
    output logic [columns-1:0]        row_r,
    output logic [columns-1:0]        row_g,
    output logic [columns-1:0]        row_b,
    output logic                      frame_done,
    output logic                      err
);
    localparam int RW = $clog2(rows);
    localparam logic [RW-1:0]         LAST_ROW = RW'(rows - 1);
    localparam logic [cyclewidth-1:0] ON_MAX   = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOADED, DISPLAY} state_t;
    state_t state, state_nx;

    logic oclk_q, lat_q, oe_q;
    logic oclk_rise, lat_rise, oe_fall;
    logic [columns-1:0] sr_r, sr_g, sr_b;
    logic [columns-1:0] hold_r, hold_g, hold_b;
    logic [RW-1:0] held_row;
    logic [cyclewidth-1:0] on_cnt;

    assign oclk_rise = oclk & ~oclk_q;
    assign lat_rise  = lat & ~lat_q;
    assign oe_fall   = ~oe & oe_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (oclk_rise) state_nx = SHIFT;
            SHIFT:   state_nx = SHIFT;
            LOADED: begin
                if (oe)             state_nx = DISPLAY;
                else if (oclk_rise) state_nx = SHIFT;
            end
            DISPLAY: if (oe_fall) state_nx = LOADED;
            default: state_nx = IDLE;
        endcase
        // A latch wins from any state; oe already high means the row is lit this very cycle.
        if (lat_rise) state_nx = oe ? DISPLAY : LOADED;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oclk_q        <= 1'b0;
            lat_q         <= 1'b0;
            oe_q          <= 1'b0;
            sr_r          <= '0;
            sr_g          <= '0;
            sr_b          <= '0;
            hold_r        <= '0;
            hold_g        <= '0;
            hold_b        <= '0;
            held_row      <= '0;
            on_cnt        <= '0;
            row_valid     <= 1'b0;
            frame_done    <= 1'b0;
            row_index     <= '0;
            row_on_cycles <= '0;
            row_r         <= '0;
            row_g         <= '0;
            row_b         <= '0;
        end else begin
            oclk_q <= oclk;
            lat_q  <= lat;
            oe_q   <= oe;
            if (oclk_rise) begin
                sr_r <= {sr_r[columns-2:0], rgb[2]};
                sr_g <= {sr_g[columns-2:0], rgb[1]};
                sr_b <= {sr_b[columns-2:0], rgb[0]};
            end
            // Holding registers take the pre-shift contents when oclk and lat rise together.
            if (lat_rise) begin
                hold_r   <= sr_r;
                hold_g   <= sr_g;
                hold_b   <= sr_b;
                held_row <= row;
            end
            if (state != DISPLAY && state_nx == DISPLAY)
                on_cnt <= cyclewidth'(1);
            else if (state == DISPLAY && oe && on_cnt != ON_MAX)
                on_cnt <= on_cnt + cyclewidth'(1);
            row_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (state == DISPLAY && oe_fall) begin
                row_valid     <= 1'b1;
                frame_done    <= (held_row == LAST_ROW);
                row_index     <= held_row;
                row_on_cycles <= on_cnt;
                row_r         <= hold_r;
                row_g         <= hold_g;
                row_b         <= hold_b;
            end
        end
    end

`ifdef HUB75_SINK_ERR_EN
    localparam int CW = $clog2(columns + 2);
    localparam logic [CW-1:0] FULL = CW'(columns);
    localparam logic [CW-1:0] SAT  = CW'(columns + 1);

    logic [CW-1:0] shift_cnt;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt <= '0;
            err_q     <= 1'b0;
        end else if (lat_rise) begin
            shift_cnt <= oclk_rise ? CW'(1) : '0;
            if (shift_cnt != FULL) err_q <= 1'b1;
        end else if (oclk_rise && shift_cnt != SAT) begin
            shift_cnt <= shift_cnt + CW'(1);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_sink.sv
// Directed bench for hub75_sink: a bit-history scoreboard predicts every report and err, checked each cycle.
module tb_hub75_sink;
    localparam int ROWS = 8;
    localparam int COLS = 32;
    localparam int CWID = 10;
    localparam int ON_SAT = (1 << CWID) - 1;
    localparam int NEVER = 32'h7fffffff;
`ifdef HUB75_SINK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, oclk, lat, oe;
    logic [2:0] row;
    logic [2:0] rgb;
    logic row_valid, frame_done, err;
    logic [2:0] row_index;
    logic [CWID-1:0] row_on_cycles;
    logic [COLS-1:0] row_r, row_g, row_b;

    hub75_sink #(.rows(ROWS), .columns(COLS), .cyclewidth(CWID)) dut (
        .clk(clk), .rst(rst), .oclk(oclk), .lat(lat), .oe(oe), .row(row), .rgb(rgb),
        .row_valid(row_valid), .row_index(row_index), .row_on_cycles(row_on_cycles),
        .row_r(row_r), .row_g(row_g), .row_b(row_b), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              at;
        logic [2:0]      idx;
        int              on;
        logic [COLS-1:0] r, g, b;
        logic            fd;
    } rep_t;

    rep_t expq[$];
    rep_t last;
    int   err_at = NEVER;
    int   cyc = 0;
    logic rst_s = 1'b0;
    int   nvec = 0, nmis = 0, npulse = 0, nframe = 0;

    logic [2:0]      hist[$];
    int              since_latch, m_lit;
    bit              can_disp;
    logic [COLS-1:0] m_r, m_g, m_b;
    logic [2:0]      m_row;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    function void chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        rep_t e;
        if (cyc >= 1) begin
            if (rst_s) begin
                expq.delete();
                last   = '{0, 3'd0, 0, '0, '0, '0, 1'b0};
                err_at = NEVER;
                chk("reset_flags", {row_valid, frame_done, err}, 0);
                chk("reset_index_on", {row_index, row_on_cycles}, 0);
                chk("reset_rgb", {row_r, row_g, row_b} == '0, 1);
            end else begin
                if (row_valid === 1'b1) npulse++;
                if (frame_done === 1'b1) nframe++;
                if (expq.size() > 0 && expq[0].at == cyc) begin
                    e = expq.pop_front();
                    last = e;
                    chk("row_valid_pulse", row_valid, 1);
                    chk("frame_done_pulse", frame_done, e.fd);
                end else begin
                    chk("row_valid_quiet", row_valid, 0);
                    chk("frame_done_quiet", frame_done, 0);
                end
                chk("row_index", row_index, last.idx);
                chk("row_on_cycles", row_on_cycles, last.on);
                chk("row_r", row_r, last.r);
                chk("row_g", row_g, last.g);
                chk("row_b", row_b, last.b);
                chk("err", err, ERR_EN && (cyc >= err_at));
            end
        end
    end

    // The latched row is simply the last COLS bits ever shifted, oldest at the MSB.
    function void capture();
        for (int i = 0; i < COLS; i++) begin
            int k;
            k = hist.size() - COLS + i;
            m_r[COLS-1-i] = (k >= 0) ? hist[k][2] : 1'b0;
            m_g[COLS-1-i] = (k >= 0) ? hist[k][1] : 1'b0;
            m_b[COLS-1-i] = (k >= 0) ? hist[k][0] : 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hist.delete();
        since_latch = 0;
        can_disp = 1'b0;
        m_lit = 0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic shift(input logic [2:0] v);
        rgb = v;
        oclk = 1'b1;
        tick();
        hist.push_back(v);
        if (since_latch < COLS + 1) since_latch++;
        can_disp = 1'b0;
        oclk = 1'b0;
        tick();
    endtask

    task automatic latch(input logic [2:0] r, input bit with_shift, input logic [2:0] v, input bit with_oe);
        row = r;
        lat = 1'b1;
        if (with_shift) begin
            oclk = 1'b1;
            rgb = v;
        end
        if (with_oe) oe = 1'b1;
        capture();
        m_row = r;
        if (since_latch != COLS && err_at > cyc + 1) err_at = cyc + 1;
        since_latch = with_shift ? 1 : 0;
        if (with_shift) hist.push_back(v);
        can_disp = 1'b1;
        m_lit = with_oe ? 1 : 0;
        tick();
        lat = 1'b0;
        oclk = 1'b0;
    endtask

    task automatic display(input int n);
        oe = 1'b1;
        repeat (n) tick();
        m_lit += n;
        oe = 1'b0;
        if (can_disp)
            expq.push_back('{cyc + 1, m_row, (m_lit > ON_SAT) ? ON_SAT : m_lit, m_r, m_g, m_b, m_row == 3'(ROWS - 1)});
        m_lit = 0;
        repeat (3) tick();
    endtask

    task automatic shift_n(input int n, input logic [2:0] v);
        repeat (n) shift(v);
    endtask

    int p0, f0;

    initial begin
        rst = 1'b1; oclk = 1'b0; lat = 1'b0; oe = 1'b0; row = '0; rgb = '0;
        do_reset();

        // oe with no latch since reset is ignored
        display(10);

        // single red pixel in the first column, row 3, lit 100 cycles
        shift(3'b100);
        shift_n(31, 3'b000);
        latch(3'd3, 1'b0, 3'b000, 1'b0);
        display(100);
        chk("lit_r", row_r, 32'h80000000);
        chk("lit_gb", {row_g, row_b}, 0);
        chk("lit_index", row_index, 3);
        chk("lit_on", row_on_cycles, 100);
        chk("lit_err", err, 0);

        // full frame of eight rows
        p0 = npulse; f0 = nframe;
        for (int r = 0; r < ROWS; r++) begin
            for (int i = 0; i < COLS; i++) shift(3'((i * 3 + r) % 8));
            latch(3'(r), 1'b0, 3'b000, 1'b0);
            display(50);
        end
        chk("frame_pulses", npulse - p0, 8);
        chk("frame_done_count", nframe - f0, 1);
        chk("frame_err", err, 0);

        // short row sets a sticky error
        shift_n(31, 3'b001);
        latch(3'd2, 1'b0, 3'b000, 1'b0);
        display(5);
        shift_n(32, 3'b011);
        latch(3'd1, 1'b0, 3'b000, 1'b0);
        display(5);
        chk("err_sticky", err, ERR_EN);
        chk("after_err_b", row_b, 32'hffffffff);

        // on-time counter saturates
        shift_n(32, 3'b010);
        latch(3'd1, 1'b0, 3'b000, 1'b0);
        display(2000);
        chk("on_saturate", row_on_cycles, 1023);

        // oe rising with the latch counts that first lit cycle
        shift_n(32, 3'b001);
        latch(3'd0, 1'b0, 3'b000, 1'b1);
        display(9);
        chk("oe_with_lat_on", row_on_cycles, 10);

        // shift and latch in the same cycle
        do_reset();
        shift_n(32, 3'b010);
        latch(3'd5, 1'b1, 3'b111, 1'b0);
        display(4);
        chk("same_cycle_g", row_g, 32'hffffffff);
        chk("same_cycle_rb", {row_r, row_b}, 0);
        shift_n(31, 3'b000);
        latch(3'd6, 1'b0, 3'b000, 1'b0);
        display(4);
        chk("carry_bit_r", row_r, 32'h80000000);
        chk("carry_err", err, 0);

        // reset in the middle of a lit row
        shift_n(32, 3'b100);
        latch(3'd4, 1'b0, 3'b000, 1'b0);
        p0 = npulse;
        oe = 1'b1;
        repeat (20) tick();
        do_reset();
        repeat (30) tick();
        oe = 1'b0;
        repeat (3) tick();
        chk("reset_no_report", npulse - p0, 0);
        shift_n(32, 3'b110);
        latch(3'd7, 1'b0, 3'b000, 1'b0);
        display(10);
        chk("post_reset_pulse", npulse - p0, 1);
        chk("post_reset_r", row_r, 32'hffffffff);

        repeat (3) tick();
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/hub75_sink.md
HUB75_SINK -- requirements
Module: hub75_sink

Interface
REQ-001 SHALL have parameter rows, default 8, meaning panel rows per segment.
REQ-002 SHALL have parameter columns, default 32, meaning pixels shifted per row.
REQ-003 SHALL have parameter cyclewidth, default 10, meaning on-time counter width.
REQ-004 SHALL have port clk  input  1  system clock; the single clock of the block.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have the following panel-bus inputs, all synchronous to clk:
- oclk  input  1  shift clock.
- lat  input  1  latch.
- oe  input  1  output enable; 1 means row lit.
- row  input  $clog2(rows)  row address.
- rgb  input  3  serial data; bit 2 = R, bit 1 = G, bit 0 = B.
REQ-007 SHALL have the following report outputs:
- row_valid  output  1  one-cycle report pulse.
- row_index  output  $clog2(rows)  reported row.
- row_on_cycles  output  cyclewidth  lit cycles.
- row_r, row_g, row_b  output  columns  latched bits.
- frame_done  output  1  one-cycle pulse.
- err  output  1  sticky shift-count error.

Function
REQ-008 SHALL register oclk, lat and oe each cycle; a rising edge is current=1 with previous=0, and a falling edge is the reverse.
REQ-009 On an oclk rising edge, SHALL shift rgb into three shift registers: new bit enters bit 0, existing bits move toward the MSB, so the first-shifted of columns bits lands at index columns-1.
REQ-010 SHALL count oclk rising edges since the last latch, saturating at columns+1.
REQ-011 On a lat rising edge, SHALL copy the shift registers into the holding registers, capture row into the held row, and clear the shift count.
REQ-012 On a lat rising edge where the shift count is not equal to columns, SHALL set err; err stays 1 until rst.
REQ-013 If an oclk rising edge and a lat rising edge occur in the same cycle:
- the latch SHALL capture the pre-shift contents;
- the new bit SHALL be retained and the shift count SHALL become 1.
REQ-014 SHALL implement FSM states IDLE, SHIFT, LOADED, DISPLAY:
- IDLE->SHIFT on oclk rise;
- SHIFT->LOADED on lat rise;
- LOADED->DISPLAY when oe=1;
- DISPLAY->LOADED on oe fall;
- LOADED->SHIFT on oclk rise while oe=0;
- a lat rise in any state SHALL go to LOADED.
REQ-015 In DISPLAY, SHALL increment the on counter every cycle oe=1, saturating at 2^cyclewidth-1; the counter SHALL clear on entry to DISPLAY.
REQ-016 If oe rises in the same cycle as a lat rise, SHALL apply the latch first and count the first lit cycle.
REQ-017 The cycle after an oe falling edge, SHALL pulse row_valid for 1 cycle with:
- row_index = held row;
- row_on_cycles = final count;
- row_r/g/b = holding registers.
REQ-018 Report outputs SHALL hold their values between pulses.
REQ-019 SHALL pulse frame_done together with row_valid when row_index equals rows-1.
REQ-020 oe assertion in IDLE (no latch since reset) SHALL be ignored: no count and no report.

Reset
REQ-021 With rst=1 at a clk edge, the block SHALL enter IDLE and clear every register.
REQ-022 All outputs SHALL read 0 in the cycle after reset.
REQ-023 A reset mid-shift or mid-DISPLAY SHALL discard the partial row with no report emitted.
REQ-024 Edge detectors SHALL reset to previous=0, so a line held high through reset registers a rising edge on the first cycle after reset.

Configuration
REQ-025 Macro HUB75_SINK_ERR_EN SHALL control shift-count error detection:
- defined: err behaves per REQ-012;
- undefined: err is tied to 0 and the shift-count comparison logic is not compiled.

Verification
REQ-026 Shift 32 bits with R=1 only on the first bit, latch with row=3, then oe high for 100 cycles -> one row_valid with row_index=3, row_on_cycles=100, row_r=32'h80000000, row_g=row_b=0, frame_done=0, err=0.
REQ-027 Send 8 rows (0..7), each with 32 shifts and oe for 50 cycles -> 8 row_valid pulses, frame_done only with row 7, err=0.
REQ-028 Send 31 shifts then lat -> err=1 and stays 1 through later good rows; err=0 with HUB75_SINK_ERR_EN undefined.
REQ-029 Hold oe high for 2000 cycles after a latch -> row_on_cycles=1023.
REQ-030 Apply oclk rise and lat rise in the same cycle after 32 shifts -> latched data equals the 32 prior bits, and the next latch after 31 further shifts has err=0.
REQ-031 Assert rst during DISPLAY -> no row_valid, all outputs 0 next cycle, and oe high afterwards produces no report until a new latch.
